isu_rc_arbiter: RTL and testbench

//  Shares the single SRAM controller request port (d_rc_*) among NUM_REQ isu_wrapper issue ports.

---
 rtl/isu_rc_arbiter_pkg.sv | 30 +++
 rtl/isu_rc_arbiter_if.sv | 68 ++++++
 rtl/isu_rc_arbiter_rr_pick.sv | 45 ++++
 rtl/isu_rc_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_isu_rc_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/isu_rc_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// isu_rc_arbiter_pkg
//   Shared types and helpers for the ISU -> SRAM-controller request arbiter.
//   - cache_op_e          : cache operation encoding carried on the request bus
//   - is_refill()         : true for the two refill operations (priority class)
//   - arb_src_t           : source-port index wide enough for the largest arbiter
//   - ISU_RC_ARB_MAX_REQ  : upper bound on the number of requesting ports
// -----------------------------------------------------------------------------
package isu_rc_arbiter_pkg;

  localparam int ISU_RC_ARB_MAX_REQ = 8;

  typedef logic [$clog2(ISU_RC_ARB_MAX_REQ)-1:0] arb_src_t;

  typedef enum logic [2:0] {
    CACHE_OP_LOAD         = 3'd0,
    CACHE_OP_STORE        = 3'd1,
    CACHE_OP_LOAD_REFILL  = 3'd2,
    CACHE_OP_STORE_REFILL = 3'd3,
    CACHE_OP_WRITEBACK    = 3'd4,
    CACHE_OP_INVALIDATE   = 3'd5,
    CACHE_OP_FLUSH        = 3'd6,
    CACHE_OP_NOP          = 3'd7
  } cache_op_e;

  function automatic logic is_refill(input cache_op_e op);
    return (op == CACHE_OP_LOAD_REFILL) || (op == CACHE_OP_STORE_REFILL);
  endfunction

endpackage

// File: rtl/isu_rc_arbiter_if.sv
// -----------------------------------------------------------------------------
// isu_rc_arbiter_if
//   Bundles the NUM_REQ-wide issue-port request side and the single SRAM
//   controller request side of the arbiter.
//   modport slave  : the arbiter (consumes req_*, drives req_ready and d_rc_*)
//   modport master : the environment (issue ports + SRAM controller)
//   Signals:
//     req_valid / req_ready          per-port handshake
//     req_channel_1hot_id, req_rob_id, req_op, req_set, req_way,
//     req_wbuf_id, req_refill_data   per-port request payload
//     d_rc_valid / d_rc_ready        controller handshake
//     d_rc_src_id                    winning port (response routing)
//     d_rc_*                         registered copy of the winning payload
//     arb_busy                       any request pending or output valid
// -----------------------------------------------------------------------------
interface isu_rc_arbiter_if #(
  parameter int  NUM_REQ         = 4,
  parameter type setWidth_t      = logic,
  parameter type wayIndexWidth_t = logic,
  parameter type wbufWidth_t     = logic,
  parameter type robWidth_t      = logic
);
  import isu_rc_arbiter_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  // request side
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [2:0]         req_channel_1hot_id [NUM_REQ];
  robWidth_t          req_rob_id          [NUM_REQ];
  cache_op_e          req_op              [NUM_REQ];
  setWidth_t          req_set             [NUM_REQ];
  wayIndexWidth_t     req_way             [NUM_REQ];
  wbufWidth_t         req_wbuf_id         [NUM_REQ];
  logic [127:0]       req_refill_data     [NUM_REQ];

  // controller side
  logic               d_rc_valid;
  logic               d_rc_ready;
  logic [IDX_W-1:0]   d_rc_src_id;
  logic [2:0]         d_rc_channel_1hot_id;
  robWidth_t          d_rc_rob_id;
  cache_op_e          d_rc_op;
  setWidth_t          d_rc_set;
  wayIndexWidth_t     d_rc_way;
  wbufWidth_t         d_rc_wbuf_id;
  logic [127:0]       d_rc_refill_data;

  logic               arb_busy;

  modport slave (
    input  req_valid, req_channel_1hot_id, req_rob_id, req_op, req_set,
           req_way, req_wbuf_id, req_refill_data, d_rc_ready,
    output req_ready, d_rc_valid, d_rc_src_id, d_rc_channel_1hot_id,
           d_rc_rob_id, d_rc_op, d_rc_set, d_rc_way, d_rc_wbuf_id,
           d_rc_refill_data, arb_busy
  );

  modport master (
    output req_valid, req_channel_1hot_id, req_rob_id, req_op, req_set,
           req_way, req_wbuf_id, req_refill_data, d_rc_ready,
    input  req_ready, d_rc_valid, d_rc_src_id, d_rc_channel_1hot_id,
           d_rc_rob_id, d_rc_op, d_rc_set, d_rc_way, d_rc_wbuf_id,
           d_rc_refill_data, arb_busy
  );

endinterface

// File: rtl/isu_rc_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// isu_rc_arbiter_rr_pick
//   Combinational round-robin picker: returns the first set bit of vec_i at an
//   index >= ptr_i, wrapping around to index 0 if none is found above ptr_i.
//   Ports:
//     vec_i    in  N        candidate vector
//     ptr_i    in  clog2(N) round-robin start position
//     any_o    out 1        vec_i has at least one bit set
//     idx_o    out clog2(N) index of the chosen bit (0 when any_o=0)
//     onehot_o out N        one-hot of the chosen bit (0 when any_o=0)
// -----------------------------------------------------------------------------
module isu_rc_arbiter_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         vec_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic                 any_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic [N-1:0]         onehot_o
);
  localparam int W = $clog2(N);

  // Candidates at or above the pointer get first pick.
  logic [N-1:0] hi_vec;

  for (genvar gi = 0; gi < N; gi++) begin : g_hi
    assign hi_vec[gi] = vec_i[gi] & (W'(gi) >= ptr_i);
  end

  always_comb begin
    any_o    = |vec_i;
    idx_o    = '0;
    onehot_o = '0;
    // Scanning downward leaves the lowest index; the masked pass runs second
    // so an upper-half hit overrides the wrapped lowest bit.
    for (int k = N - 1; k >= 0; k--) begin
      if (vec_i[k]) idx_o = W'(k);
    end
    for (int k = N - 1; k >= 0; k--) begin
      if (hi_vec[k]) idx_o = W'(k);
    end
    if (any_o) onehot_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/isu_rc_arbiter.sv
// -----------------------------------------------------------------------------
// isu_rc_arbiter
//   Shares the single SRAM controller request port among NUM_REQ issue ports.
//   Two round-robin classes: refill ops win over the rest, but after
//   STARVE_LIMIT consecutive refill grants with a non-refill request waiting,
//   the non-refill class is served once. One registered output stage gives a
//   1-cycle latency and full throughput while d_rc_ready stays high.
//   Ports:
//     clk                 in   clock
//     rst                 in   asynchronous reset, active-high
//     bus_if (slave)      request side + controller side, see isu_rc_arbiter_if
//     perf_grant_cnt_o    out  32b per port, accepts per port (wrapping)
//     perf_stall_cnt_o    out  32b, cycles with d_rc_valid & ~d_rc_ready
//   The two perf ports exist only when ISU_RC_ARB_PERF_CNT_EN is defined;
//   arbitration is identical either way.
// -----------------------------------------------------------------------------
module isu_rc_arbiter #(
  parameter int  NUM_REQ         = 4,
  parameter int  STARVE_LIMIT    = 8,
  parameter type setWidth_t      = logic,
  parameter type wayIndexWidth_t = logic,
  parameter type wbufWidth_t     = logic,
  parameter type robWidth_t      = logic
) (
  input  logic                clk,
  input  logic                rst,
`ifdef ISU_RC_ARB_PERF_CNT_EN
  output logic [31:0]         perf_grant_cnt_o [NUM_REQ],
  output logic [31:0]         perf_stall_cnt_o,
`endif
  isu_rc_arbiter_if.slave     bus_if
);
  import isu_rc_arbiter_pkg::*;

  localparam int         IDX_W      = $clog2(NUM_REQ);
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  typedef struct packed {
    logic [2:0]       channel;
    robWidth_t        rob_id;
    cache_op_e        op;
    setWidth_t        set;
    wayIndexWidth_t   way;
    wbufWidth_t       wbuf_id;
    logic [127:0]     refill_data;
    logic [IDX_W-1:0] src_id;
  } rc_beat_t;

  // state
  rc_beat_t         beat_q, beat_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] ptr_rf_q, ptr_rf_d;
  logic [IDX_W-1:0] ptr_nr_q, ptr_nr_d;
  logic [7:0]       starve_cnt_q, starve_cnt_d;

  // arbitration
  logic [NUM_REQ-1:0] rf_vec, nr_vec, rf_1hot, nr_1hot, req_ready_w;
  logic               rf_any, nr_any, use_rf, win_any, adv, accept;
  logic [IDX_W-1:0]   rf_idx, nr_idx, win_idx;
  rc_beat_t           win_beat;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_class
    assign rf_vec[gi] = bus_if.req_valid[gi] & is_refill(bus_if.req_op[gi]);
  end
  assign nr_vec = bus_if.req_valid & ~rf_vec;

  isu_rc_arbiter_rr_pick #(.N(NUM_REQ)) u_pick_rf (
    .vec_i    (rf_vec),
    .ptr_i    (ptr_rf_q),
    .any_o    (rf_any),
    .idx_o    (rf_idx),
    .onehot_o (rf_1hot)
  );

  isu_rc_arbiter_rr_pick #(.N(NUM_REQ)) u_pick_nr (
    .vec_i    (nr_vec),
    .ptr_i    (ptr_nr_q),
    .any_o    (nr_any),
    .idx_o    (nr_idx),
    .onehot_o (nr_1hot)
  );

  always_comb begin
    adv     = ~valid_q | bus_if.d_rc_ready;
    // Refill wins unless a non-refill request has waited through the limit.
    use_rf  = rf_any & (~nr_any | (starve_cnt_q < STARVE_MAX));
    win_any = use_rf ? rf_any : nr_any;
    win_idx = use_rf ? rf_idx : nr_idx;
    // No grant while reset is held, so nothing is accepted and then dropped.
    accept  = adv & win_any & ~rst;
    req_ready_w = '0;
    if (accept) req_ready_w = use_rf ? rf_1hot : nr_1hot;

    win_beat.channel     = bus_if.req_channel_1hot_id[win_idx];
    win_beat.rob_id      = bus_if.req_rob_id[win_idx];
    win_beat.op          = bus_if.req_op[win_idx];
    win_beat.set         = bus_if.req_set[win_idx];
    win_beat.way         = bus_if.req_way[win_idx];
    win_beat.wbuf_id     = bus_if.req_wbuf_id[win_idx];
    win_beat.refill_data = bus_if.req_refill_data[win_idx];
    win_beat.src_id      = win_idx;
  end

  always_comb begin
    beat_d       = beat_q;
    valid_d      = valid_q;
    ptr_rf_d     = ptr_rf_q;
    ptr_nr_d     = ptr_nr_q;
    starve_cnt_d = starve_cnt_q;

    if (accept) begin
      beat_d  = win_beat;
      valid_d = 1'b1;
      if (use_rf) ptr_rf_d = next_ptr(win_idx);
      else        ptr_nr_d = next_ptr(win_idx);
    end else if (adv) begin
      // Output drained with nothing new: drop valid, keep data for debug.
      valid_d = 1'b0;
    end

    if (!nr_any) begin
      starve_cnt_d = '0;
    end else if (accept) begin
      if (!use_rf)                          starve_cnt_d = '0;
      else if (starve_cnt_q != STARVE_MAX)  starve_cnt_d = starve_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q       <= '0;
      valid_q      <= 1'b0;
      ptr_rf_q     <= '0;
      ptr_nr_q     <= '0;
      starve_cnt_q <= '0;
    end else begin
      beat_q       <= beat_d;
      valid_q      <= valid_d;
      ptr_rf_q     <= ptr_rf_d;
      ptr_nr_q     <= ptr_nr_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign bus_if.req_ready            = req_ready_w;
  assign bus_if.d_rc_valid           = valid_q;
  assign bus_if.d_rc_src_id          = beat_q.src_id;
  assign bus_if.d_rc_channel_1hot_id = beat_q.channel;
  assign bus_if.d_rc_rob_id          = beat_q.rob_id;
  assign bus_if.d_rc_op              = beat_q.op;
  assign bus_if.d_rc_set             = beat_q.set;
  assign bus_if.d_rc_way             = beat_q.way;
  assign bus_if.d_rc_wbuf_id         = beat_q.wbuf_id;
  assign bus_if.d_rc_refill_data     = beat_q.refill_data;
  assign bus_if.arb_busy             = (|bus_if.req_valid) | valid_q;

`ifdef ISU_RC_ARB_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
    logic [31:0] grant_cnt_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                  grant_cnt_q <= '0;
      else if (req_ready_w[gi]) grant_cnt_q <= grant_cnt_q + 32'd1;
    end
    assign perf_grant_cnt_o[gi] = grant_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 stall_cnt_q <= '0;
    else if (valid_q & ~bus_if.d_rc_ready)   stall_cnt_q <= stall_cnt_q + 32'd1;
  end
  assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_isu_rc_arbiter.sv
// Self-checking bench for isu_rc_arbiter: directed scenarios plus a randomized
// run, all compared against a behavioural model of the arbitration rules.
module tb_isu_rc_arbiter;
  import isu_rc_arbiter_pkg::*;

  localparam int N      = 4;
  localparam int STARVE = 8;
  localparam int SIG_W  = 3 + 6 + 3 + 8 + 2 + 4 + 128;

  typedef logic [7:0] set_t;
  typedef logic [1:0] way_t;
  typedef logic [3:0] wbuf_t;
  typedef logic [5:0] rob_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  isu_rc_arbiter_if #(.NUM_REQ(N), .setWidth_t(set_t), .wayIndexWidth_t(way_t),
                      .wbufWidth_t(wbuf_t), .robWidth_t(rob_t)) bus_if ();

`ifdef ISU_RC_ARB_PERF_CNT_EN
  logic [31:0] perf_grant_cnt [N];
  logic [31:0] perf_stall_cnt;
`endif

  isu_rc_arbiter #(.NUM_REQ(N), .STARVE_LIMIT(STARVE), .setWidth_t(set_t),
                   .wayIndexWidth_t(way_t), .wbufWidth_t(wbuf_t), .robWidth_t(rob_t)) dut (
    .clk              (clk),
    .rst              (rst),
`ifdef ISU_RC_ARB_PERF_CNT_EN
    .perf_grant_cnt_o (perf_grant_cnt),
    .perf_stall_cnt_o (perf_stall_cnt),
`endif
    .bus_if           (bus_if)
  );

  // ---------------- behavioural model ----------------
  int               m_ptr_rf, m_ptr_nr, m_starve, m_src;
  bit               m_valid;
  logic [SIG_W-1:0] m_sig;
  int               exp_win;
  bit               exp_rf, exp_nr_any;
  logic [N-1:0]     exp_ready;

  function automatic bit refill_op(input cache_op_e op);
    return op == CACHE_OP_LOAD_REFILL || op == CACHE_OP_STORE_REFILL;
  endfunction

  function automatic logic [SIG_W-1:0] port_sig(input int p);
    return {bus_if.req_channel_1hot_id[p], bus_if.req_rob_id[p], bus_if.req_op[p],
            bus_if.req_set[p], bus_if.req_way[p], bus_if.req_wbuf_id[p],
            bus_if.req_refill_data[p]};
  endfunction

  function automatic logic [SIG_W-1:0] out_sig();
    return {bus_if.d_rc_channel_1hot_id, bus_if.d_rc_rob_id, bus_if.d_rc_op,
            bus_if.d_rc_set, bus_if.d_rc_way, bus_if.d_rc_wbuf_id, bus_if.d_rc_refill_data};
  endfunction

  task automatic model_reset();
    m_ptr_rf = 0; m_ptr_nr = 0; m_starve = 0; m_src = 0; m_valid = 0; m_sig = '0;
  endtask

  // Decide this cycle's winner from the current inputs and model state.
  task automatic model_pick();
    bit any_rf = 0;
    int base;
    exp_nr_any = 0;
    exp_win    = -1;
    exp_rf     = 0;
    for (int i = 0; i < N; i++) begin
      if (bus_if.req_valid[i]) begin
        if (refill_op(bus_if.req_op[i])) any_rf = 1;
        else                             exp_nr_any = 1;
      end
    end
    if (!rst && (!m_valid || bus_if.d_rc_ready) && (any_rf || exp_nr_any)) begin
      exp_rf = any_rf && (!exp_nr_any || m_starve < STARVE);
      base   = exp_rf ? m_ptr_rf : m_ptr_nr;
      for (int k = 0; k < N; k++) begin
        int p = (base + k) % N;
        if (exp_win < 0 && bus_if.req_valid[p] && refill_op(bus_if.req_op[p]) == exp_rf)
          exp_win = p;
      end
    end
    exp_ready = '0;
    if (exp_win >= 0) exp_ready[exp_win] = 1'b1;
  endtask

  // Apply one clock edge to the model and to the DUT.
  task automatic model_clock();
    bit adv = !m_valid || bus_if.d_rc_ready;
    model_pick();
    if (exp_win >= 0) begin
      m_valid = 1; m_src = exp_win; m_sig = port_sig(exp_win);
      if (exp_rf) m_ptr_rf = (exp_win + 1) % N;
      else        m_ptr_nr = (exp_win + 1) % N;
    end else if (adv) begin
      m_valid = 0;
    end
    if (!exp_nr_any)       m_starve = 0;
    else if (exp_win >= 0) m_starve = exp_rf ? ((m_starve < STARVE) ? m_starve + 1 : STARVE) : 0;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_port(input int p, input bit v, input cache_op_e op);
    bus_if.req_valid[p]           = v;
    bus_if.req_op[p]              = op;
    bus_if.req_channel_1hot_id[p] = 3'b001 << $urandom_range(0, 2);
    bus_if.req_rob_id[p]          = rob_t'($urandom);
    bus_if.req_set[p]             = set_t'($urandom);
    bus_if.req_way[p]             = way_t'($urandom);
    bus_if.req_wbuf_id[p]         = wbuf_t'($urandom);
    bus_if.req_refill_data[p]     = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drive_idle();
    for (int p = 0; p < N; p++) drive_port(p, 1'b0, CACHE_OP_LOAD);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus_if.d_rc_ready = 1'b1;
    for (int p = 0; p < N; p++) drive_port(p, 1'b1, CACHE_OP_LOAD);
    model_reset();
    #2;
    checks++; if (bus_if.d_rc_valid !== 1'b0) begin failures++;
      $display("FAIL reset_valid: got %b expected 0", bus_if.d_rc_valid); end
    checks++; if (bus_if.req_ready !== 4'b0000) begin failures++;
      $display("FAIL reset_ready: got %b expected 0000", bus_if.req_ready); end
    checks++; if (out_sig() !== '0 || bus_if.d_rc_src_id !== 2'd0) begin failures++;
      $display("FAIL reset_data: got %h/%0d expected 0", out_sig(), bus_if.d_rc_src_id); end
    @(posedge clk); #1;
    drive_idle();
    rst = 1'b0;
    #1;
    checks++; if (bus_if.arb_busy !== 1'b0 || bus_if.req_ready !== 4'b0000) begin failures++;
      $display("FAIL idle_after_reset: busy=%b ready=%b expected 0/0000", bus_if.arb_busy, bus_if.req_ready); end
    model_clock();
  endtask

  task automatic test_rr_loads();
    for (int c = 0; c < 12; c++) begin
      logic [N-1:0] want;
      for (int p = 0; p < N; p++) drive_port(p, 1'b1, CACHE_OP_LOAD);
      want = 4'b0001 << (c % 4);
      #1;
      checks++; if (bus_if.req_ready !== want) begin failures++;
        $display("FAIL rr_ready c=%0d: got %b expected %b", c, bus_if.req_ready, want); end
      if (c > 0) begin
        checks++; if (bus_if.d_rc_valid !== 1'b1 || bus_if.d_rc_src_id !== 2'((c - 1) % 4)) begin failures++;
          $display("FAIL rr_src c=%0d: got v=%b src=%0d expected v=1 src=%0d", c,
                   bus_if.d_rc_valid, bus_if.d_rc_src_id, (c - 1) % 4); end
        checks++; if (out_sig() !== m_sig) begin failures++;
          $display("FAIL rr_data c=%0d: got %h expected %h", c, out_sig(), m_sig); end
      end
      model_clock();
    end
  endtask

  task automatic test_refill_priority();
    drive_idle();
    drive_port(2, 1'b1, CACHE_OP_LOAD_REFILL);
    drive_port(0, 1'b1, CACHE_OP_LOAD);
    #1;
    checks++; if (bus_if.req_ready !== 4'b0100) begin failures++;
      $display("FAIL prio_first: got %b expected 0100", bus_if.req_ready); end
    model_clock();
    bus_if.req_valid[2] = 1'b0;
    #1;
    checks++; if (bus_if.req_ready !== 4'b0001 || bus_if.d_rc_src_id !== 2'd2) begin failures++;
      $display("FAIL prio_second: got ready=%b src=%0d expected 0001/2", bus_if.req_ready, bus_if.d_rc_src_id); end
    model_clock();
    bus_if.req_valid[0] = 1'b0;
    #1;
    checks++; if (bus_if.d_rc_valid !== 1'b1 || bus_if.d_rc_src_id !== 2'd0) begin failures++;
      $display("FAIL prio_out: got v=%b src=%0d expected 1/0", bus_if.d_rc_valid, bus_if.d_rc_src_id); end
    model_clock();
  endtask

  task automatic test_starvation();
    drive_idle();
    drive_port(1, 1'b1, CACHE_OP_LOAD_REFILL);
    drive_port(3, 1'b1, CACHE_OP_STORE_REFILL);
    drive_port(0, 1'b1, CACHE_OP_LOAD);
    for (int r = 0; r < 2; r++) begin
      int  n_rf = 0;
      bit  got  = 0;
      for (int c = 0; c < 40 && !got; c++) begin
        #1;
        model_pick();
        checks++; if (bus_if.req_ready !== exp_ready) begin failures++;
          $display("FAIL starve_ready r=%0d c=%0d: got %b expected %b", r, c, bus_if.req_ready, exp_ready); end
        if (bus_if.req_ready[0]) got = 1;
        else if (bus_if.req_ready[1] || bus_if.req_ready[3]) n_rf++;
        model_clock();
      end
      checks++; if (!got || n_rf != STARVE) begin failures++;
        $display("FAIL starve_count r=%0d: got %0d refill grants (port0 granted=%0d) expected %0d",
                 r, n_rf, got, STARVE); end
    end
    drive_idle();
    model_clock();
  endtask

  task automatic test_stall();
    logic [SIG_W-1:0] a5_sig, b5_sig;
    drive_idle();
    bus_if.d_rc_ready             = 1'b1;
    bus_if.req_valid[1]           = 1'b1;
    bus_if.req_op[1]              = CACHE_OP_LOAD;
    bus_if.req_channel_1hot_id[1] = 3'b010;
    bus_if.req_rob_id[1]          = 6'h25;
    bus_if.req_set[1]             = 8'hA5;
    bus_if.req_way[1]             = 2'h1;
    bus_if.req_wbuf_id[1]         = 4'h5;
    bus_if.req_refill_data[1]     = {16{8'hA5}};
    a5_sig = {3'b010, 6'h25, CACHE_OP_LOAD, 8'hA5, 2'h1, 4'h5, {16{8'hA5}}};
    #1;
    checks++; if (bus_if.req_ready !== 4'b0010) begin failures++;
      $display("FAIL stall_accept: got %b expected 0010", bus_if.req_ready); end
    model_clock();
    bus_if.d_rc_ready         = 1'b0;
    bus_if.req_set[1]         = 8'h5A;
    bus_if.req_refill_data[1] = {16{8'h5A}};
    b5_sig = {3'b010, 6'h25, CACHE_OP_LOAD, 8'h5A, 2'h1, 4'h5, {16{8'h5A}}};
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (bus_if.req_ready !== 4'b0000) begin failures++;
        $display("FAIL stall_ready c=%0d: got %b expected 0000", c, bus_if.req_ready); end
      checks++; if (bus_if.d_rc_valid !== 1'b1 || bus_if.d_rc_src_id !== 2'd1 || out_sig() !== a5_sig) begin failures++;
        $display("FAIL stall_hold c=%0d: got v=%b src=%0d data=%h expected 1/1/%h", c,
                 bus_if.d_rc_valid, bus_if.d_rc_src_id, out_sig(), a5_sig); end
      model_clock();
    end
    bus_if.d_rc_ready = 1'b1;
    #1;
    checks++; if (bus_if.req_ready !== 4'b0010) begin failures++;
      $display("FAIL stall_resume: got %b expected 0010", bus_if.req_ready); end
    model_clock();
    bus_if.req_valid[1] = 1'b0;
    #1;
    checks++; if (out_sig() !== b5_sig) begin failures++;
      $display("FAIL stall_next_data: got %h expected %h", out_sig(), b5_sig); end
    model_clock();
  endtask

  task automatic test_reset_midflight();
    bus_if.d_rc_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int p = 0; p < N; p++) drive_port(p, 1'b1, CACHE_OP_LOAD);
      model_clock();
    end
    rst = 1'b1;
    #1;
    checks++; if (bus_if.d_rc_valid !== 1'b0 || bus_if.req_ready !== 4'b0000) begin failures++;
      $display("FAIL rst_mid: got v=%b ready=%b expected 0/0000", bus_if.d_rc_valid, bus_if.req_ready); end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (bus_if.req_ready !== 4'b0001) begin failures++;
      $display("FAIL rst_first_grant: got %b expected 0001", bus_if.req_ready); end
    model_clock();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < N; p++)
        drive_port(p, $urandom_range(0, 99) < 60, cache_op_e'($urandom_range(0, 7)));
      bus_if.d_rc_ready = $urandom_range(0, 99) < 70;
      #1;
      model_pick();
      checks++; if (bus_if.req_ready !== exp_ready) begin failures++;
        $display("FAIL rand_ready c=%0d: got %b expected %b", c, bus_if.req_ready, exp_ready); end
      checks++; if (bus_if.d_rc_valid !== m_valid) begin failures++;
        $display("FAIL rand_valid c=%0d: got %b expected %b", c, bus_if.d_rc_valid, m_valid); end
      checks++; if (bus_if.arb_busy !== ((|bus_if.req_valid) | m_valid)) begin failures++;
        $display("FAIL rand_busy c=%0d: got %b expected %b", c, bus_if.arb_busy, (|bus_if.req_valid) | m_valid); end
      if (m_valid) begin
        checks++; if (bus_if.d_rc_src_id !== 2'(m_src) || out_sig() !== m_sig) begin failures++;
          $display("FAIL rand_beat c=%0d: got src=%0d data=%h expected src=%0d data=%h",
                   c, bus_if.d_rc_src_id, out_sig(), m_src, m_sig); end
      end
      model_clock();
    end
    drive_idle();
    bus_if.d_rc_ready = 1'b1;
    model_clock();
  endtask

`ifdef ISU_RC_ARB_PERF_CNT_EN
  task automatic test_perf();
    drive_idle();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    bus_if.d_rc_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      drive_port(2, 1'b1, CACHE_OP_STORE);
      model_clock();
    end
    drive_idle();
    bus_if.d_rc_ready = 1'b0;
    for (int c = 0; c < 3; c++) model_clock();
    bus_if.d_rc_ready = 1'b1;
    #1;
    checks++; if (perf_grant_cnt[2] !== 32'd10) begin failures++;
      $display("FAIL perf_grant: got %0d expected 10", perf_grant_cnt[2]); end
    checks++; if (perf_stall_cnt !== 32'd3) begin failures++;
      $display("FAIL perf_stall: got %0d expected 3", perf_stall_cnt); end
    model_clock();
  endtask
`endif

  initial begin
    test_reset();
    test_rr_loads();
    test_refill_priority();
    test_starvation();
    test_stall();
    test_reset_midflight();
    test_random();
`ifdef ISU_RC_ARB_PERF_CNT_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
